// File: rtl/p405s_itlb_ctl_pkg.sv
// p405s_itlb_ctl_pkg: refill FSM state type and default shadow ITLB depth
package p405s_itlb_ctl_pkg;
  localparam int ITLB_NUM_WORDS = 4;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DRAIN} itlb_state_t;
endpackage

// File: rtl/p405s_itlb_refill_ctl_if.sv
// p405s_itlb_refill_ctl_if: UTLB refill request/grant/done handshake
interface p405s_itlb_refill_ctl_if;
  logic utlbReq;
  logic utlbGnt;
  logic utlbDone;
  logic utlbHit;
  modport master (output utlbReq, input utlbGnt, utlbDone, utlbHit);
  modport slave (input utlbReq, output utlbGnt, utlbDone, utlbHit);
endinterface

// File: rtl/p405s_itlb_victim_sel.sv
// p405s_itlb_victim_sel: round-robin victim pointer, lowest invalid word first under P405S_ITLB_INV_FIRST_EN
module p405s_itlb_victim_sel import p405s_itlb_ctl_pkg::*; #(
  parameter int NUM_WORDS = ITLB_NUM_WORDS,
  localparam int IW = $clog2(NUM_WORDS)
) (
  input  logic                 CB,
  input  logic                 Reset_N,
  input  logic [NUM_WORDS-1:0] wordValid,
  input  logic                 sample,
  input  logic                 advance,
  output logic [IW-1:0]        victim
);
  logic [IW-1:0] ptr;
`ifdef P405S_ITLB_INV_FIRST_EN
  logic [IW-1:0] first_inv;
  logic any_inv, use_rr;
  always_comb begin
    first_inv = '0;
    any_inv = 1'b0;
    for (int i = NUM_WORDS - 1; i >= 0; i--) begin
      if (!wordValid[i]) begin
        first_inv = IW'(i);
        any_inv = 1'b1;
      end
    end
  end
  always_ff @(posedge CB or negedge Reset_N) begin
    if (!Reset_N) begin
      ptr <= '0;
      victim <= '0;
      use_rr <= 1'b0;
    end else begin
      if (sample) begin
        victim <= any_inv ? first_inv : ptr;
        use_rr <= !any_inv;
      end
      if (advance && use_rr) ptr <= ptr + IW'(1);
    end
  end
`else
  logic unused_sel;
  assign unused_sel = ^{wordValid, sample};
  always_ff @(posedge CB or negedge Reset_N) begin
    if (!Reset_N) ptr <= '0;
    else if (advance) ptr <= ptr + IW'(1);
  end
  assign victim = ptr;
`endif
endmodule

// File: rtl/p405s_itlb_refill_ctl.sv
// p405s_itlb_refill_ctl: ITLB miss refill sequencer with flash invalidate; P405S_ITLB_INV_FIRST_EN enables invalid-first victim choice
module p405s_itlb_refill_ctl import p405s_itlb_ctl_pkg::*; #(
  parameter int NUM_WORDS = ITLB_NUM_WORDS
) (
  input  logic                   CB,
  input  logic                   Reset_N,
  input  logic                   isMiss,
  input  logic                   isFetchVal,
  input  logic                   isAbort_N,
  input  logic [NUM_WORDS-1:0]   wordValid,
  input  logic                   invalAll,
  p405s_itlb_refill_ctl_if.master utlb,
  output logic [NUM_WORDS-1:0]   WordSel_N,
  output logic                   writeShadow,
  output logic                   invalidate,
  output logic                   refillBusy,
  output logic                   itlbMissExc
);
  itlb_state_t state, state_nxt;
  logic [$clog2(NUM_WORDS)-1:0] victim;
  logic inv_pend, inv_issue, miss_exc, req_q;
  p405s_itlb_victim_sel #(.NUM_WORDS(NUM_WORDS)) u_victim (
    .CB(CB),
    .Reset_N(Reset_N),
    .wordValid(wordValid),
    .sample(state == WAIT),
    .advance(state == WRITE),
    .victim(victim)
  );
  always_comb begin
    state_nxt = state;
    inv_issue = 1'b0;
    miss_exc = 1'b0;
    case (state)
      IDLE: begin
        inv_issue = invalAll | inv_pend;
        state_nxt = (!inv_issue && isMiss && isFetchVal && isAbort_N) ? REQ : IDLE;
      end
      REQ: state_nxt = (req_q && utlb.utlbGnt) ? (isAbort_N ? WAIT : DRAIN) : (isAbort_N ? REQ : IDLE);
      WAIT: begin
        miss_exc = utlb.utlbDone && !utlb.utlbHit && isAbort_N;
        state_nxt = utlb.utlbDone ? ((utlb.utlbHit && isAbort_N) ? WRITE : IDLE) : (isAbort_N ? WAIT : DRAIN);
      end
      WRITE: state_nxt = IDLE;
      DRAIN: state_nxt = utlb.utlbDone ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CB or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= IDLE;
      inv_pend <= 1'b0;
      req_q <= 1'b0;
      WordSel_N <= '1;
      writeShadow <= 1'b0;
      invalidate <= 1'b0;
      refillBusy <= 1'b0;
      itlbMissExc <= 1'b0;
    end else begin
      state <= state_nxt;
      inv_pend <= (state == IDLE) ? 1'b0 : (inv_pend | invalAll);
      req_q <= (state == REQ) && isAbort_N && !(req_q && utlb.utlbGnt);
      WordSel_N <= (state == WRITE) ? ~(NUM_WORDS'(1) << victim) : '1;
      writeShadow <= state == WRITE;
      invalidate <= inv_issue;
      refillBusy <= state != IDLE;
      itlbMissExc <= miss_exc;
    end
  end
  assign utlb.utlbReq = req_q;
endmodule
